// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states, ALU control codes and decode helpers.
// Optional build macro MULDIV_ITER_MULT_EN selects the iterative multiplier (see hilo_muldiv.sv).
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    MUL_RUN = 2'd2,
    DONE    = 2'd3
  } muldiv_state_t;

  // One iteration per operand bit
  localparam int MULDIV_CYCLES = 32;

  localparam logic [4:0] MULT_CONTROL  = 5'd16;
  localparam logic [4:0] MULTU_CONTROL = 5'd17;
  localparam logic [4:0] DIV_CONTROL   = 5'd18;
  localparam logic [4:0] DIVU_CONTROL  = 5'd19;
  localparam logic [4:0] MTHI_CONTROL  = 5'd20;
  localparam logic [4:0] MTLO_CONTROL  = 5'd21;

  function automatic logic is_muldiv_code(input logic [4:0] c);
    return (c == MULT_CONTROL) || (c == MULTU_CONTROL) || (c == DIV_CONTROL) ||
           (c == DIVU_CONTROL) || (c == MTHI_CONTROL) || (c == MTLO_CONTROL);
  endfunction

  function automatic logic is_div_code(input logic [4:0] c);
    return (c == DIV_CONTROL) || (c == DIVU_CONTROL);
  endfunction

  function automatic logic is_mul_code(input logic [4:0] c);
    return (c == MULT_CONTROL) || (c == MULTU_CONTROL);
  endfunction

  function automatic logic is_signed_code(input logic [4:0] c);
    return (c == MULT_CONTROL) || (c == DIV_CONTROL);
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, plus the shared iteration counter.
// quot_next/rem_next expose the result of the step being taken this cycle.
module hilo_muldiv_div_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          clear,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quot_next,
  output logic [DW-1:0] rem_next,
  output logic          last
);

  localparam int CW = $clog2(DW);

  logic [DW-1:0] rem;
  logic [DW-1:0] quot;
  logic [DW-1:0] dvsr;
  logic [CW-1:0] cnt;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;

  // Remainder stays below the divisor, so DW+1 bits always hold the trial subtraction
  always_comb begin
    shifted   = {rem, quot[DW-1]};
    diff      = shifted - {1'b0, dvsr};
    rem_next  = diff[DW] ? shifted[DW-1:0] : diff[DW-1:0];
    quot_next = {quot[DW-2:0], ~diff[DW]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quot <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      rem  <= '0;
      quot <= dividend;
      dvsr <= divisor;
      cnt  <= '0;
    end else if (step) begin
      rem  <= rem_next;
      quot <= quot_next;
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(DW - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO multiply/divide unit with a 32-step restoring divider and pipeline stall.
// Define MULDIV_ITER_MULT_EN to replace the single-cycle multiplier with a 32-step shift-add (state MUL_RUN).
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DW = MULDIV_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic [4:0]    alucontrol,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          stall_o
);

  muldiv_state_t state, state_next;

  logic [DW-1:0] hi, lo;
  logic          neg_q, neg_r, div_zero;
  logic [DW-1:0] a_hold;
  logic          accept, accept_long, signed_op;
  logic [DW-1:0] mag_a, mag_b;
  logic [DW-1:0] quot_next, rem_next;
  logic [DW-1:0] quot_fix, rem_fix;
  logic          last, running, finish_div;

  assign accept    = (state == IDLE) && start && !flush && is_muldiv_code(alucontrol);
  assign signed_op = is_signed_code(alucontrol);
  assign mag_a     = (signed_op && a[DW-1]) ? (~a) + 1'b1 : a;
  assign mag_b     = (signed_op && b[DW-1]) ? (~b) + 1'b1 : b;
  assign running   = (state == DIV_RUN) || (state == MUL_RUN);
  assign finish_div = (state == DIV_RUN) && !flush && last;

`ifdef MULDIV_ITER_MULT_EN
  assign accept_long = accept && (is_div_code(alucontrol) || is_mul_code(alucontrol));
`else
  assign accept_long = accept && is_div_code(alucontrol);
`endif

  assign stall_o = accept_long || (running && !flush);

  hilo_muldiv_div_core #(.DW(DW)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (running && !flush),
    .clear     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quot_next (quot_next),
    .rem_next  (rem_next),
    .last      (last)
  );

  assign quot_fix = neg_q ? (~quot_next) + 1'b1 : quot_next;
  assign rem_fix  = neg_r ? (~rem_next) + 1'b1 : rem_next;

`ifdef MULDIV_ITER_MULT_EN
  logic [2*DW-1:0] prod, prod_next, prod_fix;
  logic [DW-1:0]   mcand;
  logic [DW:0]     psum;
  logic            finish_mul;

  // Multiplier sits in the low half and shifts out as the product shifts in
  always_comb begin
    psum      = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_next = {psum, prod[DW-1:1]};
    prod_fix  = neg_q ? (~prod_next) + 1'b1 : prod_next;
  end

  assign finish_mul = (state == MUL_RUN) && !flush && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod  <= '0;
      mcand <= '0;
    end else if (accept) begin
      prod  <= {{DW{1'b0}}, mag_b};
      mcand <= mag_a;
    end else if (state == MUL_RUN && !flush) begin
      prod <= prod_next;
    end
  end
`else
  logic [2*DW-1:0] prod_s, prod_u;
  assign prod_s = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_div_code(alucontrol)) state_next = DIV_RUN;
`ifdef MULDIV_ITER_MULT_EN
        if (accept && is_mul_code(alucontrol)) state_next = MUL_RUN;
`endif
      end
      DIV_RUN: begin
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
`ifdef MULDIV_ITER_MULT_EN
      MUL_RUN: begin
        if (flush)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_hold   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        neg_q    <= signed_op & (a[DW-1] ^ b[DW-1]);
        neg_r    <= signed_op & a[DW-1];
        div_zero <= (b == '0);
        a_hold   <= a;
        case (alucontrol)
          MTHI_CONTROL:  hi <= a;
          MTLO_CONTROL:  lo <= a;
`ifndef MULDIV_ITER_MULT_EN
          MULT_CONTROL:  {hi, lo} <= prod_s;
          MULTU_CONTROL: {hi, lo} <= prod_u;
`endif
          default: ;
        endcase
      end else if (finish_div) begin
        hi <= div_zero ? a_hold : rem_fix;
        lo <= div_zero ? '1 : quot_fix;
      end
`ifdef MULDIV_ITER_MULT_EN
      else if (finish_mul) begin
        {hi, lo} <= prod_fix;
      end
`endif
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed corner cases plus random traffic against an arithmetic model.
// Honours MULDIV_ITER_MULT_EN for expected multiply latency.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int DW = 32;
  localparam int DIV_STALLS = 33;
`ifdef MULDIV_ITER_MULT_EN
  localparam int MUL_STALLS = 33;
`else
  localparam int MUL_STALLS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [4:0]    alucontrol = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [DW-1:0] hi_o, lo_o;
  logic          stall_o;

  hilo_muldiv #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic and SV signed division semantics
  task automatic model_apply(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                             output exp_t e);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    e.stalls = 0;
    case (c)
      MTHI_CONTROL: m_hi = x;
      MTLO_CONTROL: m_lo = x;
      MULT_CONTROL: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {m_hi, m_lo} = sp;
        e.stalls = MUL_STALLS;
      end
      MULTU_CONTROL: begin
        up = {32'b0, x};
        up = up * {32'b0, y};
        {m_hi, m_lo} = up;
        e.stalls = MUL_STALLS;
      end
      DIVU_CONTROL: begin
        if (y == 0) begin m_hi = x; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = x / y; m_hi = x % y; end
        e.stalls = DIV_STALLS;
      end
      DIV_CONTROL: begin
        if (y == 0) begin m_hi = x; m_lo = 32'hFFFF_FFFF; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin m_lo = x; m_hi = 0; end
        else begin
          sx = x; sy = y;
          m_lo = sx / sy;
          m_hi = sx % sy;
        end
        e.stalls = DIV_STALLS;
      end
      default: ;
    endcase
    e.code = c;
    e.hi   = m_hi;
    e.lo   = m_lo;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction has left EX
  task automatic issue(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   n;
    model_apply(c, x, y, e);
    sb.push_back(e);
    start = 1'b1; alucontrol = c; a = x; b = y;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL timeout code=%0d stall cycles=%0d required<=%0d", c, n, DIV_STALLS);
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: counts stall cycles per instruction, compares HI/LO the cycle after it leaves EX
  initial begin
    int   stall_cnt;
    int   pend_stalls;
    logic pending;
    exp_t e;
    stall_cnt = 0; pend_stalls = 0; pending = 1'b0;
    forever begin
      @(negedge clk);
      if (pending) begin
        pending = 1'b0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty actual=retire required=no_retire");
        end else begin
          e = sb.pop_front();
          $display("txn code=%0d hi=%h lo=%h stalls=%0d", e.code, hi_o, lo_o, pend_stalls);
          check("hi", hi_o, e.hi);
          check("lo", lo_o, e.lo);
          check("stalls", 32'(pend_stalls), 32'(e.stalls));
        end
      end
      if (rst) stall_cnt = 0;
      else if (flush) stall_cnt = 0;
      else if (start && stall_o) stall_cnt++;
      else if (start) begin
        pending = 1'b1;
        pend_stalls = stall_cnt;
        stall_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] rand_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 20));
      4: begin v = 32'($urandom_range(1, 20)); v = -v; end
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [4:0] ops [7];
    ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL,
            MTHI_CONTROL, MTLO_CONTROL, 5'd3};

    #1;
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(DIVU_CONTROL, 32'd100, 32'd7);
    issue(DIV_CONTROL, -32'd7, 32'd2);
    issue(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(MULT_CONTROL, 32'hFFFF_FFFF, 32'd2);
    issue(MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2);
    issue(DIVU_CONTROL, 32'h1234, 32'd0);
    issue(DIV_CONTROL, -32'd9, 32'd0);
    issue(DIV_CONTROL, 32'd7, -32'd2);
    issue(MTHI_CONTROL, 32'h1111_2222, 32'd0);
    issue(MTLO_CONTROL, 32'h3333_4444, 32'd0);
    issue(5'd3, 32'hDEAD_BEEF, 32'h1);

    // Flush at DIV_RUN cnt=10: no write, stall drops in the flush cycle
    start = 1'b1; alucontrol = DIV_CONTROL; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    #1 check("flush_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_hi", hi_o, m_hi);
    check("flush_lo", lo_o, m_lo);
    issue(MTHI_CONTROL, 32'h0000_ABCD, 32'd0);

    // Flush in IDLE suppresses an MTLO in the same cycle
    start = 1'b1; alucontrol = MTLO_CONTROL; a = 32'h5A5A_5A5A; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("idle_flush_lo", lo_o, m_lo);

    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 6)], rand_opnd(), rand_opnd());
    end

    // Asynchronous reset between edges while a divide is running
    issue(MTLO_CONTROL, 32'h7777_0001, 32'd0);
    start = 1'b1; alucontrol = DIVU_CONTROL; a = 32'd5000; b = 32'd13;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1; start = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    issue(DIVU_CONTROL, 32'd100, 32'd7);
    issue(MTLO_CONTROL, 32'h0BAD_F00D, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
